// File: rtl/alu_issue_ctrl.sv
// Issue controller for the combinational ALU: accepts one micro-instruction, reads operands,
// checks the condition against the stored flags, drives the ALU and writes the result back.
//
// state | meaning
// IDLE  | ready for a new instruction
// RD    | operands and op registered onto the ALU ports, condition evaluated
// EX    | ALU evaluating; result and flags captured at the end of the cycle
// WB    | writeback strobe, register file written at the end of the cycle
// SKIP  | condition failed, one-cycle skipped pulse
module alu_issue_ctrl #(
    parameter int DATA_W = 32,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ins_valid,
    output logic              ins_ready,
    input  logic [3:0]        ins_op,
    input  logic [2:0]        ins_rd,
    input  logic [2:0]        ins_ra,
    input  logic [2:0]        ins_rb,
    input  logic              ins_imm_en,
    input  logic [DATA_W-1:0] ins_imm,
    input  logic              ins_setf,
    input  logic [3:0]        ins_cond,
    output logic [3:0]        aluop,
    output logic [DATA_W-1:0] opA,
    output logic [DATA_W-1:0] opB,
    output logic              flagin,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_flag,
    output logic              wb_valid,
    output logic [2:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [3:0]        flags_q,
    output logic              skipped
);

    typedef enum logic [2:0] {IDLE, RD, EX, WB, SKIP} stateT;

    stateT state, stateNext;

    logic [3:0]        opQ;
    logic [2:0]        rdQ, raQ, rbQ;
    logic              immEnQ, setfQ;
    logic [DATA_W-1:0] immQ;
    logic [3:0]        condQ;
    logic [DATA_W-1:0] regFile [NREG];
    logic [DATA_W-1:0] readA, readB;
    logic              condPass;
    logic              flagN, flagZ, flagC, flagV;

    assign {flagN, flagZ, flagC, flagV} = flags_q;

    // R0 is hardwired to zero on the read side; its storage is never written.
    assign readA = (raQ == 3'd0) ? '0 : regFile[raQ];
    assign readB = (rbQ == 3'd0) ? '0 : regFile[rbQ];

    always_comb begin
        condPass = 1'b0;
        case (condQ)
            4'd0:    condPass = 1'b1;
            4'd1:    condPass = flagZ;
            4'd2:    condPass = !flagZ;
            4'd3:    condPass = flagC;
            4'd4:    condPass = !flagC;
            4'd5:    condPass = flagN;
            4'd6:    condPass = !flagN;
            4'd7:    condPass = flagV;
            4'd8:    condPass = !flagV;
            4'd9:    condPass = (flagN == flagV);
            4'd10:   condPass = (flagN != flagV);
            4'd11:   condPass = !flagZ && (flagN == flagV);
            4'd12:   condPass = flagZ || (flagN != flagV);
            default: condPass = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        ins_ready = 1'b0;
        flagin    = 1'b0;
        wb_valid  = 1'b0;
        skipped   = 1'b0;
        case (state)
            IDLE: begin
                ins_ready = 1'b1;
                if (ins_valid) stateNext = RD;
            end
            RD:   stateNext = condPass ? EX : SKIP;
            EX: begin
                flagin    = setfQ;
                stateNext = WB;
            end
            WB: begin
                wb_valid  = 1'b1;
                stateNext = IDLE;
            end
            SKIP: begin
                skipped   = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign wb_rd = rdQ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opQ    <= '0;
            rdQ    <= '0;
            raQ    <= '0;
            rbQ    <= '0;
            immEnQ <= 1'b0;
            immQ   <= '0;
            setfQ  <= 1'b0;
            condQ  <= '0;
        end else if (state == IDLE && ins_valid) begin
            opQ    <= ins_op;
            rdQ    <= ins_rd;
            raQ    <= ins_ra;
            rbQ    <= ins_rb;
            immEnQ <= ins_imm_en;
            immQ   <= ins_imm;
            setfQ  <= ins_setf;
            condQ  <= ins_cond;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluop   <= '0;
            opA     <= '0;
            opB     <= '0;
            wb_data <= '0;
            flags_q <= '0;
            for (int i = 0; i < NREG; i++) regFile[i] <= '0;
        end else begin
            if (state == RD) begin
                aluop <= opQ;
                opA   <= readA;
                opB   <= immEnQ ? immQ : readB;
            end
            if (state == EX) begin
                wb_data <= alu_result;
                if (setfQ) flags_q <= alu_flag;
            end
            if (state == WB && rdQ != 3'd0) regFile[rdQ] <= wb_data;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: plays the ALU itself and checks every instruction against a
// register/flag reference model, covering directed cases, random traffic and mid-run reset.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ins_valid = 1'b0;
    logic        ins_ready;
    logic [3:0]  ins_op = '0;
    logic [2:0]  ins_rd = '0, ins_ra = '0, ins_rb = '0;
    logic        ins_imm_en = 1'b0;
    logic [31:0] ins_imm = '0;
    logic        ins_setf = 1'b0;
    logic [3:0]  ins_cond = '0;
    logic [3:0]  aluop;
    logic [31:0] opA, opB;
    logic        flagin;
    logic [31:0] alu_result;
    logic [3:0]  alu_flag;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [31:0] wb_data;
    logic [3:0]  flags_q;
    logic        skipped;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acceptCyc = 0;

    logic [31:0] mReg [8];
    logic [3:0]  mFlags;

    alu_issue_ctrl #(.DATA_W(32), .NREG(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .ins_valid(ins_valid), .ins_ready(ins_ready),
        .ins_op(ins_op), .ins_rd(ins_rd), .ins_ra(ins_ra), .ins_rb(ins_rb),
        .ins_imm_en(ins_imm_en), .ins_imm(ins_imm), .ins_setf(ins_setf), .ins_cond(ins_cond),
        .aluop(aluop), .opA(opA), .opB(opB), .flagin(flagin),
        .alu_result(alu_result), .alu_flag(alu_flag),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .flags_q(flags_q), .skipped(skipped)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU behaviour: returns {N,Z,C,V, result}; C on subtract means "no borrow".
    function automatic logic [35:0] aluRef(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic c, v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'd1: begin
                r = a - b;
                c = (a >= b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            default: r = b;
        endcase
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    function automatic bit condRef(input logic [3:0] cond, input logic [3:0] f);
        bit n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            0: return 1;
            1: return z;
            2: return !z;
            3: return c;
            4: return !c;
            5: return n;
            6: return !n;
            7: return v;
            8: return !v;
            9: return n == v;
            10: return n != v;
            11: return !z && (n == v);
            12: return z || (n != v);
            default: return 0;
        endcase
    endfunction

    always_comb {alu_flag, alu_result} = aluRef(aluop, opA, opB);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < 8; i++) mReg[i] = '0;
        mFlags = '0;
    endtask

    // One instruction, checked cycle by cycle from accept (T) to return to IDLE.
    task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra,
                         input logic [2:0] rb, input logic immEn, input logic [31:0] imm,
                         input logic setf, input logic [3:0] cond, input bit dropValid);
        int n;
        logic [31:0] expA, expB;
        logic [35:0] res;
        bit pass;
        n = 0;
        while (ins_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("ready_wait", ins_ready, 1);
        ins_op = op; ins_rd = rd; ins_ra = ra; ins_rb = rb;
        ins_imm_en = immEn; ins_imm = imm; ins_setf = setf; ins_cond = cond;
        ins_valid = 1'b1;
        expA = mReg[ra];
        expB = immEn ? imm : mReg[rb];
        pass = condRef(cond, mFlags);
        res  = aluRef(op, expA, expB);
        @(posedge clk); acceptCyc = cyc; #1;
        if (dropValid) ins_valid = 1'b0;
        check("rd_ready", ins_ready, 0);
        check("rd_wbvalid", wb_valid, 0);
        @(posedge clk); #1;
        check("ex_aluop", aluop, op);
        check("ex_opA", opA, expA);
        check("ex_opB", opB, expB);
        check("ex_skipped", skipped, !pass);
        check("ex_flagin", flagin, pass && setf);
        check("ex_wbvalid", wb_valid, 0);
        @(posedge clk); #1;
        if (pass) begin
            if (setf) mFlags = res[35:32];
            if (rd != 3'd0) mReg[rd] = res[31:0];
            check("wb_valid", wb_valid, 1);
            check("wb_rd", wb_rd, rd);
            check("wb_data", wb_data, res[31:0]);
            check("wb_flags", flags_q, mFlags);
            check("wb_flagin", flagin, 0);
            check("wb_ready", ins_ready, 0);
            @(posedge clk); #1;
            check("idle_wbvalid", wb_valid, 0);
            check("idle_ready", ins_ready, 1);
        end else begin
            check("skip_wbvalid", wb_valid, 0);
            check("skip_ready", ins_ready, 1);
            check("skip_pulse", skipped, 0);
            check("skip_flags", flags_q, mFlags);
        end
    endtask

    initial begin
        int prevAccept;
        resetModel();
        #12;
        check("rst_ready", ins_ready, 1);
        check("rst_wbvalid", wb_valid, 0);
        check("rst_wbrd", wb_rd, 0);
        check("rst_wbdata", wb_data, 0);
        check("rst_flags", flags_q, 0);
        check("rst_skipped", skipped, 0);
        check("rst_aluop", aluop, 0);
        check("rst_opA", opA, 0);
        check("rst_opB", opB, 0);
        check("rst_flagin", flagin, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(4'd5, 3'd1, 3'd0, 3'd0, 1'b1, 32'h7FFF_FFFF, 1'b0, 4'd0, 1);
        check("transfer_flags", flags_q, 4'b0000);
        issue(4'd0, 3'd2, 3'd1, 3'd0, 1'b1, 32'd1, 1'b1, 4'd0, 1);
        check("add_flags", flags_q, 4'b1001);
        check("add_data", wb_data, 32'h8000_0000);
        issue(4'd5, 3'd3, 3'd0, 3'd0, 1'b1, 32'hABCD, 1'b0, 4'd1, 1);
        issue(4'd5, 3'd3, 3'd0, 3'd0, 1'b1, 32'hABCD, 1'b0, 4'd2, 1);
        check("ne_written", mReg[3], 32'hABCD);
        issue(4'd1, 3'd0, 3'd1, 3'd1, 1'b0, 32'd0, 1'b1, 4'd0, 1);
        check("sub_zflag", flags_q[2], 1);
        issue(4'd3, 3'd4, 3'd0, 3'd0, 1'b0, 32'd0, 1'b0, 4'd0, 1);

        issue(4'd2, 3'd5, 3'd1, 3'd3, 1'b0, 32'd0, 1'b0, 4'd0, 0);
        prevAccept = acceptCyc;
        for (int k = 0; k < 2; k++) begin
            issue(4'd4, 3'(6 + k), 3'd1, 3'd3, 1'b0, 32'd0, 1'b1, 4'd0, 0);
            check("b2b_spacing", acceptCyc - prevAccept, 4);
            prevAccept = acceptCyc;
        end
        ins_valid = 1'b0;

        for (int k = 0; k < 40; k++) begin
            issue(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom(),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1);
        end

        issue(4'd5, 3'd1, 3'd0, 3'd0, 1'b1, 32'h1234_5678, 1'b0, 4'd0, 1);
        ins_op = 4'd0; ins_rd = 3'd5; ins_ra = 3'd1; ins_imm_en = 1'b1;
        ins_imm = 32'hFFFF_FFFF; ins_setf = 1'b1; ins_cond = 4'd0;
        ins_valid = 1'b1;
        @(posedge clk); #1;
        ins_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_flagin", flagin, 1);
        rst_n = 1'b0;
        #1;
        resetModel();
        check("mrst_ready", ins_ready, 1);
        check("mrst_flagin", flagin, 0);
        check("mrst_wbvalid", wb_valid, 0);
        check("mrst_flags", flags_q, 0);
        check("mrst_opA", opA, 0);
        check("mrst_wbdata", wb_data, 0);
        @(posedge clk); #1;
        check("mrst_hold_wbvalid", wb_valid, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("mrst_release_ready", ins_ready, 1);
        check("mrst_release_wbvalid", wb_valid, 0);
        for (int i = 1; i < 8; i++)
            issue(4'd5, 3'd0, 3'(i), 3'(i), 1'b0, 32'd0, 1'b0, 4'd0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequencing initiator for the combinational ALU.
- Accepts one micro-instruction at a time over a valid/ready handshake and reads operands from an internal 8-entry register file.
- Evaluates a condition code against the stored flags, drives the ALU ports (aluop, opA, opB, flagin), then captures result/flag and writes back.
- Sits between the instruction decoder and the ALU.

Parameters:
- DATA_W, 32, datapath width; must equal the ALU data width.
- NREG, 8, register file depth; register index width is 3.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ins_valid  in  1  instruction valid
- ins_ready  out  1  controller can accept an instruction
- ins_op  in  4  ALU operation: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5..15 transfer opB
- ins_rd  in  3  destination register
- ins_ra  in  3  source A register
- ins_rb  in  3  source B register
- ins_imm_en  in  1  1: opB = ins_imm instead of R[rb]
- ins_imm  in  DATA_W  immediate operand
- ins_setf  in  1  update flags from this instruction
- ins_cond  in  4  execution condition (encoding below)
- aluop  out  4  to ALU
- opA  out  DATA_W  to ALU
- opB  out  DATA_W  to ALU
- flagin  out  1  to ALU, flag-update enable
- alu_result  in  DATA_W  from ALU result
- alu_flag  in  4  from ALU flag, ordered {N,Z,C,V}
- wb_valid  out  1  one-cycle writeback strobe
- wb_rd  out  3  writeback register index
- wb_data  out  DATA_W  writeback data
- flags_q  out  4  architectural flags {N,Z,C,V}
- skipped  out  1  one-cycle pulse when an instruction fails its condition

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state IDLE; ins_ready=1.
  - aluop=0, opA=0, opB=0, flagin=0.
  - wb_valid=0, wb_rd=0, wb_data=0.
  - flags_q=0, skipped=0; all registers R0..R7=0.
- Reset mid-operation: aborts immediately. No writeback, no flag update, register file cleared.
- FSM states: IDLE -> RD -> (EX -> WB | SKIP) -> IDLE.
  - IDLE: ins_ready=1. On ins_valid&ins_ready (cycle T), latch all ins_* fields and go to RD. ins_ready is 0 in every other state.
  - RD (T+1):
    - Register opA <= R[ra]; opB <= ins_imm_en ? ins_imm : R[rb]; aluop <= op.
    - Evaluate the condition against flags_q. True -> EX, false -> SKIP.
  - SKIP (T+2): skipped=1 for one cycle. No writeback, flags unchanged, ALU ports hold, flagin=0. Next state IDLE.
  - EX (T+2): aluop/opA/opB stable; flagin=setf during this cycle only. At the clock edge ending EX, register wb_data <= alu_result. If setf, flags_q <= alu_flag. Next state WB.
  - WB (T+3): wb_valid=1 and wb_rd=rd for exactly one cycle; R[rd] <= wb_data at the end of WB. Next state IDLE.
- Timing:
  - Accept-to-writeback latency is 3 cycles.
  - Back-to-back throughput is one instruction per 4 cycles; a skipped instruction also takes 3 cycles.
- Register file:
  - R0 always reads 0. Writes to R0 are discarded, but wb_valid still pulses with wb_rd=0 and wb_data = computed value.
  - Read in RD sees all earlier writebacks, because the previous WB has completed.
- Outputs aluop/opA/opB hold their last values outside RD/EX; wb_data holds until the next EX.
- Condition codes, evaluated on flags_q:
  - 0 AL always; 1 EQ Z; 2 NE !Z; 3 CS C; 4 CC !C; 5 MI N; 6 PL !N; 7 VS V; 8 VC !V.
  - 9 GE N==V; 10 LT N!=V; 11 GT !Z&(N==V); 12 LE Z|(N!=V); 13..15 NV never.
- Width rules: operands and results are DATA_W. Carry/overflow come only from the ALU; the controller performs no arithmetic.
- ins_valid while not ready is ignored. The decoder must hold the instruction until ins_ready.

Test Plan:
- Reset then ins {op=5, rd=1, imm_en=1, imm=0x7FFFFFFF, cond=AL, setf=0} at T -> wb_valid at T+3, wb_rd=1, wb_data=0x7FFFFFFF, flags_q=0.
- R1=0x7FFFFFFF, ins {op=0 add, rd=2, ra=1, imm 1, setf=1} -> wb_data=0x80000000, flags_q={N1,Z0,C0,V1}; flagin high only in EX cycle T+2.
- flags_q Z=0, ins {cond=EQ, rd=3} -> skipped pulse at T+2, no wb_valid, R3 unchanged; ins_ready returns at T+3. Same ins with cond=NE -> written.
- ins {op=1 sub, rd=0, ra=1, rb=1, setf=1} -> wb_valid with wb_rd=0, wb_data=0, flags_q Z=1; subsequent read of R0 gives 0.
- Hold ins_valid high continuously with 3 instructions -> accepts at T, T+4, T+8; ins_ready low during RD/EX/WB.
- Assert rst_n=0 during EX -> outputs reset asynchronously, no wb_valid, flags_q=0, R1..R7=0; ins_ready=1 after release.
